sdckgen_wide: RTL and testbench

//  SD-card clock generator for an NSER:1 output serdes. Emits NSER clock-line

---
 rtl/sdckgen_wide_if.sv | 25 ++
 rtl/sdckgen_wide.sv | 110 +++++++++++
 tb/tb_sdckgen_wide.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/sdckgen_wide_if.sv
// Configuration and clock-word bundle between the SDIO engines and the
// wide SD clock generator. The generator takes the slave side.
interface sdckgen_wide_if #(
   parameter int NSER     = 8,
   parameter int LGMAXDIV = 12
);
   logic                cfg_clk90;
   logic [LGMAXDIV-1:0] cfg_ckspd;
   logic                cfg_shutdown;
   logic [NSER-1:0]     ckwide;
   logic                ckstb;
   logic                hlfck;
   logic [LGMAXDIV-1:0] ckspd;
   logic                stopped;

   modport master (
      output cfg_clk90, cfg_ckspd, cfg_shutdown,
      input  ckwide, ckstb, hlfck, ckspd, stopped
   );

   modport slave (
      input  cfg_clk90, cfg_ckspd, cfg_shutdown,
      output ckwide, ckstb, hlfck, ckspd, stopped
   );
endinterface

// File: rtl/sdckgen_wide.sv
// SD-card clock generator feeding an NSER:1 serdes. Produces NSER clock-line
// bits per clk cycle with a period of 4*(D+1) bit-times, an optional
// quarter-period lead, and stop/restart only on period boundaries so the
// line never carries a runt pulse.
module sdckgen_wide #(
   parameter int NSER     = 8,
   parameter int LGMAXDIV = 12
) (
   input  logic              clk,
   input  logic              reset,
   sdckgen_wide_if.slave     bus
);
   localparam int W = LGMAXDIV + 3;

   typedef enum logic {
      ST_RUN,
      ST_STOPPED
   } state_t;

   state_t              state;
   logic [W-1:0]        phase;
   logic [LGMAXDIV-1:0] active_spd;
   logic                active_clk90;

   logic [NSER-1:0]     nxt_wide;
   logic                nxt_stb;
   logic                nxt_hlf;
   logic                nxt_halt;
   logic                nxt_stop_first;
   logic [W-1:0]        nxt_phase;
   logic [LGMAXDIV-1:0] nxt_spd;
   logic                nxt_clk90;

   // Walk the word bit by bit, latching config at each boundary and stopping at the first boundary seen with shutdown high.
   always_comb begin
      logic [W-1:0] p;
      logic [W-1:0] q;
      logic [W-1:0] q2;
      logic [W-1:0] q3;
      logic [W-1:0] q4;
      p              = (state == ST_STOPPED) ? '0 : phase;
      q              = '0;
      q2             = '0;
      q3             = '0;
      q4             = '0;
      nxt_wide       = '0;
      nxt_stb        = 1'b0;
      nxt_hlf        = 1'b0;
      nxt_halt       = 1'b0;
      nxt_stop_first = 1'b0;
      nxt_spd        = active_spd;
      nxt_clk90      = active_clk90;
      for (int b = NSER - 1; b >= 0; b--) begin
         if (!nxt_halt) begin
            if (p == '0) begin
               if (bus.cfg_shutdown) begin
                  nxt_halt       = 1'b1;
                  nxt_stop_first = (b == NSER - 1);
               end else begin
                  nxt_spd   = bus.cfg_ckspd;
                  nxt_clk90 = bus.cfg_clk90;
                  nxt_stb   = 1'b1;
               end
            end
            if (!nxt_halt) begin
               q  = W'(nxt_spd) + W'(1);
               q2 = q << 1;
               q3 = q2 + q;
               q4 = q << 2;
               if (nxt_clk90)
                  nxt_wide[b] = (p >= q) && (p < q3);
               else
                  nxt_wide[b] = (p >= q2);
               if (p == q2)
                  nxt_hlf = 1'b1;
               if (p == q4 - W'(1))
                  p = '0;
               else
                  p = p + W'(1);
            end
         end
      end
      nxt_phase = nxt_halt ? '0 : p;
   end

   // Register state, active config and every output word so the serdes sees clean flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_STOPPED;
         phase        <= '0;
         active_spd   <= '0;
         active_clk90 <= 1'b0;
         bus.ckwide   <= '0;
         bus.ckstb    <= 1'b0;
         bus.hlfck    <= 1'b0;
         bus.ckspd    <= '0;
         bus.stopped  <= 1'b1;
      end else begin
         state        <= nxt_halt ? ST_STOPPED : ST_RUN;
         phase        <= nxt_phase;
         active_spd   <= nxt_spd;
         active_clk90 <= nxt_clk90;
         bus.ckwide   <= nxt_wide;
         bus.ckstb    <= nxt_stb;
         bus.hlfck    <= nxt_hlf;
         bus.ckspd    <= nxt_spd;
         bus.stopped  <= nxt_halt && nxt_stop_first;
      end
   end
endmodule

// File: tb/tb_sdckgen_wide.sv
// Scoreboard bench for sdckgen_wide: a driver applies directed and random
// config, a bit-level reference model predicts each output word, and a
// monitor compares every registered word and checks high-pulse widths.
module tb_sdckgen_wide;
   localparam int NSER     = 8;
   localparam int LGMAXDIV = 12;

   typedef struct {
      logic [NSER-1:0]     wide;
      logic                stb;
      logic                hlf;
      logic [LGMAXDIV-1:0] spd;
      logic                stopped;
      bit                  was_reset;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   sdckgen_wide_if #(.NSER(NSER), .LGMAXDIV(LGMAXDIV)) bus ();

   sdckgen_wide #(.NSER(NSER), .LGMAXDIV(LGMAXDIV)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   m_p = 0;
   int   m_d = 0;
   bit   m_c90 = 1'b0;
   int   hi_run = 0;

   // Reference model: one clock word of the SD line from phase arithmetic.
   task automatic modelStep(input bit rst, input int d, input bit c90, input bit sd, output exp_t e);
      bit halted;
      bit first;
      int q;
      bit lvl;
      e.wide = '0;
      e.stb = 1'b0;
      e.hlf = 1'b0;
      e.was_reset = rst;
      if (rst) begin
         m_p = 0;
         m_d = 0;
         m_c90 = 1'b0;
         e.spd = '0;
         e.stopped = 1'b1;
         return;
      end
      halted = 1'b0;
      first = 1'b0;
      for (int k = 0; k < NSER; k++) begin
         if (halted) continue;
         if (m_p == 0) begin
            if (sd) begin
               halted = 1'b1;
               first = (k == 0);
               continue;
            end
            m_d = d;
            m_c90 = c90;
            e.stb = 1'b1;
         end
         q = m_d + 1;
         lvl = m_c90 ? (m_p >= q && m_p < 3 * q) : (m_p >= 2 * q);
         e.wide[NSER - 1 - k] = lvl;
         if (m_p == 2 * q) e.hlf = 1'b1;
         m_p = (m_p + 1) % (4 * q);
      end
      if (halted) m_p = 0;
      e.spd = LGMAXDIV'(m_d);
      e.stopped = halted && first;
   endtask

   task automatic applyStimulus(input bit rst, input int d, input bit c90, input bit sd);
      exp_t e;
      @(negedge clk);
      reset = rst;
      bus.cfg_ckspd = LGMAXDIV'(d);
      bus.cfg_clk90 = c90;
      bus.cfg_shutdown = sd;
      modelStep(rst, d, c90, sd, e);
      sb.push_back(e);
   endtask

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      cmp("ckwide", 32'(bus.ckwide), 32'(e.wide));
      cmp("ckstb", 32'(bus.ckstb), 32'(e.stb));
      cmp("hlfck", 32'(bus.hlfck), 32'(e.hlf));
      cmp("ckspd", 32'(bus.ckspd), 32'(e.spd));
      cmp("stopped", 32'(bus.stopped), 32'(e.stopped));
      if (e.was_reset) begin
         hi_run = 0;
      end else begin
         for (int b = NSER - 1; b >= 0; b--) begin
            if (bus.ckwide[b] === 1'b1) begin
               hi_run++;
            end else if (hi_run > 0) begin
               checks++;
               if (hi_run < 2 || (hi_run % 2) != 0) begin
                  errors++;
                  $display("[TB] FAIL pulse_width at %0t: got %0d bits expected even and >= 2", $time, hi_run);
               end
               hi_run = 0;
            end
         end
      end
   endtask

   // Monitor: one registered word per clock, compared against the oldest prediction.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput(e);
         end
      end
   end

   // Driver: directed scenarios, a maximum-divider run, then randomized config.
   initial begin
      int d;
      bit c90;
      bit sd;
      bus.cfg_ckspd = '0;
      bus.cfg_clk90 = 1'b0;
      bus.cfg_shutdown = 1'b0;
      repeat (3) applyStimulus(1, 0, 0, 0);
      repeat (6) applyStimulus(0, 0, 0, 0);
      repeat (6) applyStimulus(0, 0, 1, 0);
      repeat (6) applyStimulus(0, 1, 0, 0);
      repeat (6) applyStimulus(0, 1, 1, 0);
      repeat (8) applyStimulus(0, 3, 0, 0);
      repeat (12) applyStimulus(0, 2, 0, 0);
      repeat (6) applyStimulus(0, 3, 0, 0);
      repeat (4) applyStimulus(0, 3, 0, 1);
      repeat (6) applyStimulus(0, 3, 0, 0);
      applyStimulus(0, 3, 0, 0);
      repeat (6) applyStimulus(0, 0, 0, 0);
      repeat (7) applyStimulus(0, 2, 0, 0);
      repeat (2) applyStimulus(1, 2, 0, 0);
      repeat (9) applyStimulus(0, 2, 0, 0);
      repeat (2100) applyStimulus(0, (1 << LGMAXDIV) - 1, 1, 0);
      repeat (2100) applyStimulus(0, 0, 0, 0);
      d = 0;
      c90 = 1'b0;
      sd = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) d = $urandom_range(0, 5);
         if ($urandom_range(0, 9) == 0) c90 = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 39) == 0) sd = !sd;
         applyStimulus($urandom_range(0, 499) == 0, d, c90, sd);
      end
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: got %0d pending words expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
